pcie_rx_tlp_filter: RTL and testbench
=====================================

PCIE_RX_TLP_FILTER -- requirements
Module: pcie_rx_tlp_filter

Interface
REQ-001 SHALL have parameter UR_FIFO_DEPTH, default 4, giving the number of non-posted UR header entries; power of 2, minimum 2.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports rx_st_data in 64, rx_st_sop in 1, rx_st_eop in 1, rx_st_valid in 1, and rx_st_ready out 1: the hard-IP RX stream, ready latency 0.
REQ-005 SHALL have ports app_data out 64, app_sop out 1, app_eop out 1, app_valid out 1, and app_ready in 1: the supported-TLP stream to the application.
REQ-006 SHALL have ports ur_valid out 1, ur_ready in 1, ur_req_id out 16, ur_tag out 8, ur_tc out 3, and ur_attr out 2: the FIFO head for CplUR generation.
REQ-007 SHALL have ports ur_np_pulse out 1 and ur_p_pulse out 1: one-cycle pulses per non-posted or posted unsupported request.
REQ-008 SHALL have ports malformed_pulse out 1 and drop_count out 16: error pulse and saturating dropped-TLP counter.

Function
REQ-009 SHALL transfer an RX beat only when rx_st_valid && rx_st_ready; an app beat only when app_valid && app_ready; a UR entry only when ur_valid && ur_ready.
REQ-010 On an SOP beat, SHALL decode fmt=data[30:29], type=data[28:24], tc=data[22:20], attr=data[13:12], req_id=data[63:48], tag=data[47:40].
REQ-011 SHALL feed fmt/type to instances of is_unsupported_request and is_non_posted to classify the TLP combinationally in the SOP beat.
REQ-012 SHALL implement FSM states IDLE, PASS, and DROP; reset state is IDLE.
REQ-013 IDLE on an SOP beat: supported goes to PASS and forwards the beat; unsupported goes to DROP and discards the beat.
REQ-014 An SOP beat that also carries EOP is a TLP with an impossible length. It SHALL be dropped, pulse malformed_pulse, increment drop_count, and stay in IDLE.
REQ-015 PASS and DROP SHALL return to IDLE on the accepted EOP beat; EOP beat forwarded in PASS, discarded in DROP.
REQ-016 A non-SOP beat accepted in IDLE SHALL be discarded and SHALL pulse malformed_pulse.
REQ-017 An SOP beat while in PASS/DROP (missing EOP) SHALL pulse malformed_pulse and be reclassified as a new TLP per REQ-013/014. In PASS, the previous TLP's last forwarded beat is not patched.
REQ-018 Output SHALL be a single full register stage; rx-to-app latency is 1 cycle when app_ready is held high.
REQ-019 rx_st_ready in IDLE SHALL be (!app_valid || app_ready) && !ur_fifo_full.
REQ-020 rx_st_ready in PASS SHALL be (!app_valid || app_ready).
REQ-021 rx_st_ready in DROP SHALL be 1.
REQ-022 The app register SHALL load only forwarded beats; app_valid clears when the held beat is accepted and none loads.
REQ-023 Unsupported non-posted SOP SHALL push {req_id, tag, tc, attr} into the UR FIFO the same cycle and pulse ur_np_pulse the next cycle.
REQ-024 Unsupported posted SOP SHALL pulse ur_p_pulse the next cycle without a FIFO push.
REQ-025 The UR FIFO SHALL be first-word-fall-through: ur_valid = !empty, ur_* reflect the head, registered pointers wrap modulo UR_FIFO_DEPTH.
REQ-026 UR FIFO SHALL accept a simultaneous push and pop when full (pop frees the slot), and the occupancy count SHALL be unchanged.
REQ-027 REQ-019 SHALL make overflow impossible; no entry is ever lost or overwritten.
REQ-028 drop_count SHALL increment by 1 per dropped TLP (at its SOP) and saturate at 16'hFFFF.
REQ-029 All outputs and pulses SHALL be registered.

Reset
REQ-030 On rst assertion, outputs SHALL reset immediately: FSM IDLE, app_valid 0, app_sop/eop/data 0, FIFO empty (ur_valid 0, ur_* 0).
REQ-031 Pulses SHALL reset to 0, drop_count to 0, and rx_st_ready to 0 while rst is high.
REQ-032 Reset mid-TLP SHALL abandon it; the first post-reset beat is classified as in IDLE.

Verification
REQ-033 3DW MRd (fmt=00,type=00000), 2 beats, app_ready=1 -> both beats on app 1 cycle later with sop/eop intact; no pulses.
REQ-034 3DW IORd (fmt=00,type=00010), req_id=16'h0100, tag=8'h2A -> nothing on app; ur_np_pulse once; ur_valid=1 with req_id 0100, tag 2A; drop_count=1.
REQ-035 4DW MWr (fmt=11,type=00000), 4 beats -> discarded with rx_st_ready=1 throughout; ur_p_pulse once; FIFO unchanged.
REQ-036 UR_FIFO_DEPTH+1 back-to-back IORd with ur_ready=0 -> rx_st_ready low at the last SOP until one ur pop, then accepted.
REQ-037 CplD in flight, then sop without prior eop -> malformed_pulse; new TLP classified correctly.
REQ-038 rst asserted during a PASS TLP with app_ready=0 -> app_valid=0 immediately; next SOP forwarded normally.

Source files
------------

// File: rtl/pcie_rx_tlp_filter.sv
// RX TLP filter: forwards supported TLPs to the application, drops unsupported or malformed ones,
// and queues non-posted UR request headers for completion-with-UR generation.

module is_unsupported_request (
    input  logic [1:0] fmt,
    input  logic [4:0] tlp_type,
    output logic       unsupported
);
    // Only 3DW memory reads/writes and completions (with or without data) are handled downstream.
    always_comb begin
        unsupported = 1'b1;
        case ({fmt, tlp_type})
            7'b00_00000, 7'b10_00000, 7'b00_01010, 7'b10_01010: unsupported = 1'b0;
            default: unsupported = 1'b1;
        endcase
    end
endmodule

module is_non_posted (
    input  logic [1:0] fmt,
    input  logic [4:0] tlp_type,
    output logic       non_posted
);
    // Reads, IO, config and atomics expect a completion; writes, messages and completions do not.
    always_comb begin
        non_posted = 1'b0;
        case (tlp_type)
            5'b00000, 5'b00001: non_posted = (fmt == 2'b00) || (fmt == 2'b01);
            5'b00010, 5'b00100, 5'b00101,
            5'b01100, 5'b01101, 5'b01110: non_posted = 1'b1;
            default: non_posted = 1'b0;
        endcase
    end
endmodule

module pcie_rx_tlp_filter #(
    parameter int UR_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] rx_st_data,
    input  logic        rx_st_sop,
    input  logic        rx_st_eop,
    input  logic        rx_st_valid,
    output logic        rx_st_ready,
    output logic [63:0] app_data,
    output logic        app_sop,
    output logic        app_eop,
    output logic        app_valid,
    input  logic        app_ready,
    output logic        ur_valid,
    input  logic        ur_ready,
    output logic [15:0] ur_req_id,
    output logic [7:0]  ur_tag,
    output logic [2:0]  ur_tc,
    output logic [1:0]  ur_attr,
    output logic        ur_np_pulse,
    output logic        ur_p_pulse,
    output logic        malformed_pulse,
    output logic [15:0] drop_count
);
    localparam int AW = $clog2(UR_FIFO_DEPTH);
    localparam int EW = 29;

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
    state_t state, state_next;

    logic unsupported, non_posted;
    logic rx_fire, app_free, ur_full, ur_empty, ur_pop, ur_block, sop_ok;
    logic fwd, drop_tlp, push, p_ur, malformed;

    logic [EW-1:0] ur_mem [UR_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   ur_count;

    is_unsupported_request u_unsupported (
        .fmt         (rx_st_data[30:29]),
        .tlp_type    (rx_st_data[28:24]),
        .unsupported (unsupported)
    );

    is_non_posted u_non_posted (
        .fmt        (rx_st_data[30:29]),
        .tlp_type   (rx_st_data[28:24]),
        .non_posted (non_posted)
    );

    assign ur_empty = (ur_count == '0);
    assign ur_full  = (ur_count == (AW+1)'(UR_FIFO_DEPTH));
    assign ur_valid = !ur_empty;
    assign ur_pop   = ur_valid && ur_ready;
    assign ur_block = ur_full && !ur_pop;
    assign app_free = !app_valid || app_ready;
    assign sop_ok   = app_free && !ur_block;
    assign rx_fire  = rx_st_valid && rx_st_ready;
    assign {ur_req_id, ur_tag, ur_tc, ur_attr} = ur_empty ? '0 : ur_mem[rd_ptr];

    // Any SOP, even one that arrives mid-TLP, may forward or push, so it always needs both slots free.
    always_comb begin
        rx_st_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    rx_st_ready = sop_ok;
                PASS:    rx_st_ready = rx_st_sop ? sop_ok : app_free;
                DROP:    rx_st_ready = rx_st_sop ? sop_ok : 1'b1;
                default: rx_st_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (rx_fire) begin
            if (rx_st_sop) begin
                if (rx_st_eop)        state_next = IDLE;
                else if (unsupported) state_next = DROP;
                else                  state_next = PASS;
            end else if (rx_st_eop) begin
                state_next = IDLE;
            end
        end
    end

    always_comb begin
        fwd       = 1'b0;
        drop_tlp  = 1'b0;
        push      = 1'b0;
        p_ur      = 1'b0;
        malformed = 1'b0;
        if (rx_fire) begin
            if (rx_st_sop) begin
                malformed = rx_st_eop || (state != IDLE);
                drop_tlp  = rx_st_eop || unsupported;
                fwd       = !drop_tlp;
                push      = !rx_st_eop && unsupported && non_posted;
                p_ur      = !rx_st_eop && unsupported && !non_posted;
            end else begin
                malformed = (state == IDLE);
                fwd       = (state == PASS);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            app_valid       <= 1'b0;
            app_data        <= '0;
            app_sop         <= 1'b0;
            app_eop         <= 1'b0;
            ur_np_pulse     <= 1'b0;
            ur_p_pulse      <= 1'b0;
            malformed_pulse <= 1'b0;
            drop_count      <= '0;
        end else begin
            if (fwd) begin
                app_valid <= 1'b1;
                app_data  <= rx_st_data;
                app_sop   <= rx_st_sop;
                app_eop   <= rx_st_eop;
            end else if (app_ready) begin
                app_valid <= 1'b0;
            end
            ur_np_pulse     <= push;
            ur_p_pulse      <= p_ur;
            malformed_pulse <= malformed;
            if (drop_tlp && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    // A push and pop in the same cycle leave the occupancy unchanged, including when full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ur_count <= '0;
            for (int i = 0; i < UR_FIFO_DEPTH; i++) ur_mem[i] <= '0;
        end else begin
            if (push) begin
                ur_mem[wr_ptr] <= {rx_st_data[63:48], rx_st_data[47:40], rx_st_data[22:20], rx_st_data[13:12]};
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (ur_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, ur_pop})
                2'b10:   ur_count <= ur_count + 1'b1;
                2'b01:   ur_count <= ur_count - 1'b1;
                default: ur_count <= ur_count;
            endcase
        end
    end
endmodule

// File: tb/tb_pcie_rx_tlp_filter.sv
// Directed bench for pcie_rx_tlp_filter: forwarding, UR queueing, malformed handling and reset.

module tb_pcie_rx_tlp_filter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] rx_st_data;
    logic        rx_st_sop, rx_st_eop, rx_st_valid, rx_st_ready;
    logic [63:0] app_data;
    logic        app_sop, app_eop, app_valid, app_ready;
    logic        ur_valid, ur_ready;
    logic [15:0] ur_req_id;
    logic [7:0]  ur_tag;
    logic [2:0]  ur_tc;
    logic [1:0]  ur_attr;
    logic        ur_np_pulse, ur_p_pulse, malformed_pulse;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;
    int np_cnt = 0;
    int p_cnt = 0;
    int mal_cnt = 0;
    logic [65:0] app_q[$];

    always #5 clk = ~clk;

    pcie_rx_tlp_filter #(.UR_FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_st_data      (rx_st_data),
        .rx_st_sop       (rx_st_sop),
        .rx_st_eop       (rx_st_eop),
        .rx_st_valid     (rx_st_valid),
        .rx_st_ready     (rx_st_ready),
        .app_data        (app_data),
        .app_sop         (app_sop),
        .app_eop         (app_eop),
        .app_valid       (app_valid),
        .app_ready       (app_ready),
        .ur_valid        (ur_valid),
        .ur_ready        (ur_ready),
        .ur_req_id       (ur_req_id),
        .ur_tag          (ur_tag),
        .ur_tc           (ur_tc),
        .ur_attr         (ur_attr),
        .ur_np_pulse     (ur_np_pulse),
        .ur_p_pulse      (ur_p_pulse),
        .malformed_pulse (malformed_pulse),
        .drop_count      (drop_count)
    );

    // Observe accepted application beats and pulses mid-cycle, away from the sampling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (app_valid && app_ready) app_q.push_back({app_sop, app_eop, app_data});
            if (ur_np_pulse) np_cnt++;
            if (ur_p_pulse) p_cnt++;
            if (malformed_pulse) mal_cnt++;
        end
    end

    function automatic logic [63:0] hdr(input logic [1:0] fmt, input logic [4:0] typ, input logic [2:0] tc,
                                        input logic [1:0] attr, input logic [15:0] rid, input logic [7:0] tag);
        logic [63:0] h;
        h = 64'h0000_0000_0000_0ABC;
        h[63:48] = rid;
        h[47:40] = tag;
        h[30:29] = fmt;
        h[28:24] = typ;
        h[22:20] = tc;
        h[13:12] = attr;
        return h;
    endfunction

    task automatic clear_obs();
        np_cnt = 0;
        p_cnt = 0;
        mal_cnt = 0;
        app_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; waits reports extra cycles (>100 means gave up).
    task automatic send_beat(input logic [63:0] d, input logic s, input logic e, output int waits);
        logic done;
        rx_st_data  = d;
        rx_st_sop   = s;
        rx_st_eop   = e;
        rx_st_valid = 1'b1;
        waits = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (rx_st_ready || waits > 100) done = 1'b1;
            else waits++;
            @(posedge clk);
            #1;
        end
        rx_st_valid = 1'b0;
        rx_st_sop   = 1'b0;
        rx_st_eop   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_st_data = '0; rx_st_sop = 1'b0; rx_st_eop = 1'b0; rx_st_valid = 1'b0;
        app_ready = 1'b1; ur_ready = 1'b0;
        idle(3);
        checks++; if (app_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_app_valid got=%0h exp=0", app_valid); end
        checks++; if (ur_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ur_valid got=%0h exp=0", ur_valid); end
        checks++; if (drop_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_drop_count got=%0h exp=0", drop_count); end
        checks++; if (rx_st_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_ready got=%0h exp=0", rx_st_ready); end
        checks++; if ({ur_np_pulse, ur_p_pulse, malformed_pulse} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses got=%0b exp=000", {ur_np_pulse, ur_p_pulse, malformed_pulse}); end
        checks++; if ({ur_req_id, ur_tag, app_data} !== 88'h0) begin errors++; $display("[TB] FAIL reset_data got=%0h exp=0", {ur_req_id, ur_tag, app_data}); end
        rst = 1'b0;
        idle(1);
        clear_obs();
    endtask

    task automatic test_mrd();
        logic [63:0] h;
        int w0, w1;
        h = hdr(2'b00, 5'b00000, 3'd1, 2'd0, 16'h1234, 8'h05);
        clear_obs();
        send_beat(h, 1'b1, 1'b0, w0);
        checks++; if ({app_valid, app_sop, app_eop, app_data} !== {3'b110, h}) begin errors++; $display("[TB] FAIL mrd_beat0_latency got=%0h exp=%0h", {app_valid, app_sop, app_eop, app_data}, {3'b110, h}); end
        send_beat(64'h1111_2222_3333_4444, 1'b0, 1'b1, w1);
        checks++; if ({app_valid, app_sop, app_eop, app_data} !== {3'b101, 64'h1111_2222_3333_4444}) begin errors++; $display("[TB] FAIL mrd_beat1_latency got=%0h exp=%0h", {app_valid, app_sop, app_eop, app_data}, {3'b101, 64'h1111_2222_3333_4444}); end
        idle(3);
        checks++; if (w0 + w1 !== 0) begin errors++; $display("[TB] FAIL mrd_waits got=%0d exp=0", w0 + w1); end
        checks++; if (app_q.size() !== 2) begin errors++; $display("[TB] FAIL mrd_app_beats got=%0d exp=2", app_q.size()); end
        checks++; if (np_cnt + p_cnt + mal_cnt !== 0) begin errors++; $display("[TB] FAIL mrd_pulses got=%0d exp=0", np_cnt + p_cnt + mal_cnt); end
        checks++; if (app_valid !== 1'b0) begin errors++; $display("[TB] FAIL mrd_app_drained got=%0h exp=0", app_valid); end
    endtask

    task automatic test_iord();
        int w0, w1;
        clear_obs();
        send_beat(hdr(2'b00, 5'b00010, 3'd3, 2'd2, 16'h0100, 8'h2A), 1'b1, 1'b0, w0);
        send_beat(64'hCAFE_F00D_0000_0000, 1'b0, 1'b1, w1);
        idle(3);
        checks++; if (app_q.size() !== 0) begin errors++; $display("[TB] FAIL iord_app_beats got=%0d exp=0", app_q.size()); end
        checks++; if (np_cnt !== 1) begin errors++; $display("[TB] FAIL iord_np_pulses got=%0d exp=1", np_cnt); end
        checks++; if (p_cnt !== 0) begin errors++; $display("[TB] FAIL iord_p_pulses got=%0d exp=0", p_cnt); end
        checks++; if (ur_valid !== 1'b1) begin errors++; $display("[TB] FAIL iord_ur_valid got=%0h exp=1", ur_valid); end
        checks++; if (ur_req_id !== 16'h0100) begin errors++; $display("[TB] FAIL iord_req_id got=%0h exp=0100", ur_req_id); end
        checks++; if (ur_tag !== 8'h2A) begin errors++; $display("[TB] FAIL iord_tag got=%0h exp=2a", ur_tag); end
        checks++; if ({ur_tc, ur_attr} !== {3'd3, 2'd2}) begin errors++; $display("[TB] FAIL iord_tc_attr got=%0h exp=%0h", {ur_tc, ur_attr}, {3'd3, 2'd2}); end
        checks++; if (drop_count !== 16'd1) begin errors++; $display("[TB] FAIL iord_drop_count got=%0d exp=1", drop_count); end
        ur_ready = 1'b1;
        idle(1);
        ur_ready = 1'b0;
        checks++; if (ur_valid !== 1'b0) begin errors++; $display("[TB] FAIL iord_pop_empty got=%0h exp=0", ur_valid); end
    endtask

    task automatic test_mwr_4dw();
        int w;
        int total;
        clear_obs();
        total = 0;
        send_beat(hdr(2'b11, 5'b00000, 3'd0, 2'd0, 16'h0300, 8'h01), 1'b1, 1'b0, w); total += w;
        send_beat(64'h0000_0001_0000_0000, 1'b0, 1'b0, w); total += w;
        send_beat(64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 1'b0, w); total += w;
        send_beat(64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, w); total += w;
        idle(3);
        checks++; if (total !== 0) begin errors++; $display("[TB] FAIL mwr_ready_throughout got=%0d stalls exp=0", total); end
        checks++; if (p_cnt !== 1) begin errors++; $display("[TB] FAIL mwr_p_pulses got=%0d exp=1", p_cnt); end
        checks++; if (np_cnt !== 0) begin errors++; $display("[TB] FAIL mwr_np_pulses got=%0d exp=0", np_cnt); end
        checks++; if (app_q.size() !== 0) begin errors++; $display("[TB] FAIL mwr_app_beats got=%0d exp=0", app_q.size()); end
        checks++; if (ur_valid !== 1'b0) begin errors++; $display("[TB] FAIL mwr_fifo_unchanged got=%0h exp=0", ur_valid); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("[TB] FAIL mwr_drop_count got=%0d exp=2", drop_count); end
    endtask

    task automatic test_fifo_full();
        int w;
        int total;
        logic stalled;
        clear_obs();
        total = 0;
        for (int i = 0; i < DEPTH; i++) begin
            send_beat(hdr(2'b00, 5'b00010, 3'd0, 2'd0, 16'(16'h0200 + i), 8'(8'h10 + i)), 1'b1, 1'b0, w); total += w;
            send_beat(64'h0, 1'b0, 1'b1, w); total += w;
        end
        checks++; if (total !== 0) begin errors++; $display("[TB] FAIL fifo_fill_stalls got=%0d exp=0", total); end
        checks++; if ({ur_valid, ur_tag} !== {1'b1, 8'h10}) begin errors++; $display("[TB] FAIL fifo_head_first got=%0h exp=%0h", {ur_valid, ur_tag}, {1'b1, 8'h10}); end
        rx_st_data  = hdr(2'b00, 5'b00010, 3'd0, 2'd0, 16'h0204, 8'h14);
        rx_st_sop   = 1'b1;
        rx_st_eop   = 1'b0;
        rx_st_valid = 1'b1;
        stalled = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rx_st_ready !== 1'b0) stalled = 1'b0;
        end
        checks++; if (stalled !== 1'b1) begin errors++; $display("[TB] FAIL fifo_full_backpressure got=%0b exp=1", stalled); end
        @(posedge clk); #1;
        ur_ready = 1'b1;
        @(negedge clk);
        checks++; if (rx_st_ready !== 1'b1) begin errors++; $display("[TB] FAIL fifo_push_with_pop_ready got=%0h exp=1", rx_st_ready); end
        @(posedge clk); #1;
        ur_ready = 1'b0;
        rx_st_valid = 1'b0;
        rx_st_sop = 1'b0;
        send_beat(64'h0, 1'b0, 1'b1, w);
        checks++; if ({ur_req_id, ur_tag} !== {16'h0201, 8'h11}) begin errors++; $display("[TB] FAIL fifo_head_after_pop got=%0h exp=%0h", {ur_req_id, ur_tag}, {16'h0201, 8'h11}); end
        for (int i = 1; i <= DEPTH; i++) begin
            checks++; if ({ur_valid, ur_tag} !== {1'b1, 8'(8'h10 + i)}) begin errors++; $display("[TB] FAIL fifo_drain_order got=%0h exp=%0h", {ur_valid, ur_tag}, {1'b1, 8'(8'h10 + i)}); end
            ur_ready = 1'b1;
            idle(1);
            ur_ready = 1'b0;
        end
        checks++; if (ur_valid !== 1'b0) begin errors++; $display("[TB] FAIL fifo_empty_after_drain got=%0h exp=0", ur_valid); end
        checks++; if (np_cnt !== DEPTH + 1) begin errors++; $display("[TB] FAIL fifo_np_pulses got=%0d exp=%0d", np_cnt, DEPTH + 1); end
        checks++; if (drop_count !== 16'd7) begin errors++; $display("[TB] FAIL fifo_drop_count got=%0d exp=7", drop_count); end
    endtask

    task automatic test_malformed();
        logic [63:0] cpld, mrd;
        int w;
        cpld = hdr(2'b10, 5'b01010, 3'd0, 2'd1, 16'h0400, 8'h33);
        mrd  = hdr(2'b00, 5'b00000, 3'd2, 2'd0, 16'h0500, 8'h44);
        clear_obs();
        send_beat(64'hDEAD_0000_0000_0001, 1'b0, 1'b1, w);
        send_beat(mrd, 1'b1, 1'b1, w);
        idle(2);
        checks++; if (mal_cnt !== 2) begin errors++; $display("[TB] FAIL mal_orphan_and_single got=%0d exp=2", mal_cnt); end
        checks++; if (app_q.size() !== 0) begin errors++; $display("[TB] FAIL mal_nothing_forwarded got=%0d exp=0", app_q.size()); end
        checks++; if (drop_count !== 16'd8) begin errors++; $display("[TB] FAIL mal_drop_count got=%0d exp=8", drop_count); end
        send_beat(cpld, 1'b1, 1'b0, w);
        send_beat(64'h5555_6666_7777_8888, 1'b0, 1'b0, w);
        send_beat(mrd, 1'b1, 1'b0, w);
        send_beat(64'h9999_0000_9999_0000, 1'b0, 1'b1, w);
        idle(3);
        checks++; if (mal_cnt !== 3) begin errors++; $display("[TB] FAIL mal_missing_eop got=%0d exp=3", mal_cnt); end
        checks++; if (app_q.size() !== 4) begin errors++; $display("[TB] FAIL mal_app_beats got=%0d exp=4", app_q.size()); end
        if (app_q.size() == 4) begin
            checks++; if (app_q[1] !== {2'b00, 64'h5555_6666_7777_8888}) begin errors++; $display("[TB] FAIL mal_unpatched_beat got=%0h exp=%0h", app_q[1], {2'b00, 64'h5555_6666_7777_8888}); end
            checks++; if (app_q[2] !== {2'b10, mrd}) begin errors++; $display("[TB] FAIL mal_reclassified_sop got=%0h exp=%0h", app_q[2], {2'b10, mrd}); end
            checks++; if (app_q[3] !== {2'b01, 64'h9999_0000_9999_0000}) begin errors++; $display("[TB] FAIL mal_new_tlp_eop got=%0h exp=%0h", app_q[3], {2'b01, 64'h9999_0000_9999_0000}); end
        end
        checks++; if (drop_count !== 16'd8) begin errors++; $display("[TB] FAIL mal_supported_not_counted got=%0d exp=8", drop_count); end
    endtask

    task automatic test_reset_mid_tlp();
        logic [63:0] h;
        int w;
        h = hdr(2'b00, 5'b00000, 3'd0, 2'd0, 16'h0600, 8'h55);
        clear_obs();
        app_ready = 1'b0;
        send_beat(h, 1'b1, 1'b0, w);
        checks++; if (app_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_held got=%0h exp=1", app_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({app_valid, app_sop, rx_st_ready} !== 3'b000) begin errors++; $display("[TB] FAIL rstmid_async_clear got=%0b exp=000", {app_valid, app_sop, rx_st_ready}); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_drop_count got=%0d exp=0", drop_count); end
        idle(2);
        rst = 1'b0;
        app_ready = 1'b1;
        idle(1);
        clear_obs();
        send_beat(h, 1'b1, 1'b0, w);
        send_beat(64'h7777_7777_7777_7777, 1'b0, 1'b1, w);
        idle(3);
        checks++; if (app_q.size() !== 2) begin errors++; $display("[TB] FAIL rstmid_next_beats got=%0d exp=2", app_q.size()); end
        if (app_q.size() == 2) begin
            checks++; if (app_q[0] !== {2'b10, h}) begin errors++; $display("[TB] FAIL rstmid_next_sop got=%0h exp=%0h", app_q[0], {2'b10, h}); end
        end
        checks++; if (mal_cnt !== 0) begin errors++; $display("[TB] FAIL rstmid_no_malformed got=%0d exp=0", mal_cnt); end
    endtask

    initial begin
        test_reset();
        test_mrd();
        test_iord();
        test_mwr_4dw();
        test_fifo_full();
        test_malformed();
        test_reset_mid_tlp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
